// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data RAM between the CPU (fixed priority)
//            and a debug/loader port whose wait is bounded by STARVE_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_wren,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_q,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]        r_wait_cnt;
  logic              r_rd_pend;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_dbg_q;

  logic w_starve;
  logic w_gnt;

  // The debug side wins only when the CPU is idle or it has waited the limit.
  assign w_starve  = (r_wait_cnt == c_STARVE_LIMIT);
  assign w_gnt     = reset & dbg_req & (~cpu_req | w_starve);
  assign dbg_gnt   = w_gnt;
  assign cpu_stall = reset & dbg_req & cpu_req & w_starve;

  always_comb begin
    ram_addr   = cpu_addr;
    ram_dataIn = cpu_data;
    ram_wEn    = cpu_wren & cpu_req;
    if (w_gnt) begin
      ram_addr   = dbg_addr;
      ram_dataIn = dbg_data;
      ram_wEn    = dbg_wren;
    end
    if (!reset) begin
      ram_wEn = 1'b0;
    end
  end

  assign cpu_q      = ram_dataOut;
  assign dbg_rvalid = reset & r_rvalid;
  assign dbg_q      = r_dbg_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wait_cnt <= 8'd0;
      r_rd_pend  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_dbg_q    <= '0;
    end else begin
      if (!dbg_req || w_gnt) begin
        r_wait_cnt <= 8'd0;
      end else if (!w_starve) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      // RAM read data appears one cycle after the grant; capture it then.
      r_rd_pend <= w_gnt & ~dbg_wren;
      r_rvalid  <= r_rd_pend;
      if (r_rd_pend) begin
        r_dbg_q <= ram_dataOut;
      end
    end
  end

endmodule
`default_nettype wire
